// File: rtl/sobel_pkg.sv
// Shared types and default dimensions for the Sobel window generator.
// Windows are 3x3 taps, indexed t = 3*row + col from the top-left.
package sobel_pkg;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } win_state_t;

    localparam int DEF_IMG_WIDTH   = 720;
    localparam int DEF_IMG_HEIGHT  = 540;
    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int WIN_TAPS        = 9;

    typedef logic [WIN_TAPS-1:0][DEF_PIXEL_WIDTH-1:0] sobel_win_t;

endpackage

// File: rtl/shift_reg.sv
// Enable-gated fixed-length delay line.
// data_out is data_in delayed by SHIFT_REG_LENGTH enabled cycles.
module shift_reg #(
    parameter int DATA_WIDTH       = 8,
    parameter int SHIFT_REG_LENGTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [SHIFT_REG_LENGTH-1:0][DATA_WIDTH-1:0] sr_q;

    // NOTE: the whole delay line is reset so that every frame after reset sees known contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (valid_in) begin
            sr_q[0] <= data_in;
            for (int i = 1; i < SHIFT_REG_LENGTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign data_out = sr_q[SHIFT_REG_LENGTH-1];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streaming 3x3 window generator: pops pixels, builds raster-order windows with
// border flags, and sequences each frame through fill, run and zero flush.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PIXEL_WIDTH-1:0]   in_dout,
    input  logic                     in_empty,
    output logic                     in_rd_en,
    input  logic                     out_full,
    output logic                     out_wr_en,
    output logic [9*PIXEL_WIDTH-1:0] out_win,
    output logic                     out_border,
    output logic                     frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef logic [PIXEL_WIDTH-1:0] pix_t;

    win_state_t         state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d, crow_q, crow_d;
    logic [COL_W-1:0]   col_q, col_d, ccol_q, ccol_d;
    pix_t [2:0][2:0]    tap_q, tap_d;
    pix_t               shift_in, mid_line, top_line;
    logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic               out_border_q, out_border_d;
    logic [9*PIXEL_WIDTH-1:0] out_win_q, out_win_d;
    logic               en, load, border_next, centre_last;

    // Bottom row feeds the middle line delay, middle row feeds the top one.
    shift_reg #(.DATA_WIDTH(PIXEL_WIDTH), .SHIFT_REG_LENGTH(IMG_WIDTH - 3)) u_line_mid (
        .clock(clock), .reset(reset), .valid_in(en), .data_in(tap_q[2][0]), .data_out(mid_line)
    );
    shift_reg #(.DATA_WIDTH(PIXEL_WIDTH), .SHIFT_REG_LENGTH(IMG_WIDTH - 3)) u_line_top (
        .clock(clock), .reset(reset), .valid_in(en), .data_in(tap_q[1][0]), .data_out(top_line)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    assign centre_last = (crow_q == LAST_ROW) && (ccol_q == LAST_COL);
    assign border_next = (crow_q == '0) || (crow_q == LAST_ROW) ||
                         (ccol_q == '0) || (ccol_q == LAST_COL);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (en && row_q == ROW_W'(1) && col_q == '0)    state_d = RUN;
            RUN:     if (en && row_q == LAST_ROW && col_q == LAST_COL) state_d = FLUSH;
            FLUSH:   if (load && centre_last)                         state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        en       = 1'b0;
        shift_in = in_dout;
        unique case (state_q)
            FILL:    en = !in_empty;
            RUN:     en = !in_empty && (!out_valid_q || !out_full);
            FLUSH:   begin en = !out_valid_q || !out_full; shift_in = '0; end
            default: en = 1'b0;
        endcase
        if (reset) en = 1'b0;
        load     = en && (state_q != FILL);
        in_rd_en = en && (state_q != FLUSH);
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        crow_d = crow_q;
        ccol_d = ccol_q;
        if (in_rd_en) begin
            col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
            if (col_q == LAST_COL) row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end
        if (load) begin
            ccol_d = (ccol_q == LAST_COL) ? '0 : ccol_q + 1'b1;
            if (ccol_q == LAST_COL) crow_d = (crow_q == LAST_ROW) ? '0 : crow_q + 1'b1;
        end
    end

    // Each row shifts left by one; the newest pixel enters at column 2.
    always_comb begin
        tap_d = tap_q;
        if (en) begin
            for (int dr = 0; dr < 3; dr++) begin
                tap_d[dr][0] = tap_q[dr][1];
                tap_d[dr][1] = tap_q[dr][2];
            end
            tap_d[2][2] = shift_in;
            tap_d[1][2] = mid_line;
            tap_d[0][2] = top_line;
        end
    end

    // The output register captures the post-shift window so load and shift share one cycle.
    always_comb begin
        out_wr_en    = out_valid_q && !out_full;
        out_valid_d  = out_valid_q;
        out_win_d    = out_win_q;
        out_border_d = out_border_q;
        out_last_d   = out_last_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_win_d    = border_next ? '0 : tap_d;
            out_border_d = border_next;
            out_last_d   = centre_last;
        end else if (out_wr_en) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q        <= '0;
            col_q        <= '0;
            crow_q       <= '0;
            ccol_q       <= '0;
            tap_q        <= '0;
            out_valid_q  <= 1'b0;
            out_win_q    <= '0;
            out_border_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            crow_q       <= crow_d;
            ccol_q       <= ccol_d;
            tap_q        <= tap_d;
            out_valid_q  <= out_valid_d;
            out_win_q    <= out_win_d;
            out_border_q <= out_border_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_win    = out_win_q;
    assign out_border = out_border_q;
    assign frame_done = out_wr_en && out_last_q;

endmodule
